// File: rtl/key_pkg.sv
// Shared definitions for the key conditioning stage and the LED controller.
// Mode encodings here are decoded by name on the LED controller side.
package key_pkg;

  localparam int unsigned MODE_W = 2;

  typedef logic [MODE_W-1:0] mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DOWN   = 2'd1,
    REL_DB = 2'd2
  } key_state_t;

  localparam mode_t MODE_SLOW = 2'd0;
  localparam mode_t MODE_MED  = 2'd1;
  localparam mode_t MODE_FAST = 2'd2;
  localparam mode_t MODE_OFF  = 2'd3;

  // Modulo-4 advance; the natural wrap of the 2-bit type gives 3 -> 0.
  function automatic mode_t mode_next(input mode_t m);
    return m + mode_t'(1);
  endfunction

endpackage

// File: rtl/key_mode_debounce_if.sv
// Raw key pin plus conditioned key events and mode select.
// master: the conditioning block; slave: the consumer that drives the pin model.
interface key_mode_debounce_if
  import key_pkg::*;
();

  logic  key_in;
  logic  key_level;
  logic  press_pulse;
  logic  release_pulse;
  logic  short_pulse;
  logic  long_pulse;
  mode_t mode;

  modport master (
    input  key_in,
    output key_level,
    output press_pulse,
    output release_pulse,
    output short_pulse,
    output long_pulse,
    output mode
  );

  modport slave (
    output key_in,
    input  key_level,
    input  press_pulse,
    input  release_pulse,
    input  short_pulse,
    input  long_pulse,
    input  mode
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous input bit.
// RST_VAL is loaded into both stages so reset never presents a spurious edge.
module sync_2ff #(
   parameter bit RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/key_mode_debounce.sv
// Key conditioning: synchronise, debounce, classify short/long presses and
// keep the 2-bit blink mode consumed by the LED controller.
module key_mode_debounce
   import key_pkg::*;
#(
   parameter int unsigned DB_CYCLES      = 500000,
   parameter int unsigned LONG_CYCLES    = 25000000,
   parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
   input logic                 clk,
   input logic                 rst,
   key_mode_debounce_if.master bus
);

   localparam int unsigned DB_W   = $clog2(DB_CYCLES);
   localparam int unsigned LONG_W = $clog2(LONG_CYCLES);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
   localparam logic [LONG_W-1:0] HOLD_LAST = LONG_W'(LONG_CYCLES - 1);

   logic key_sync;
   logic key_s;

   // Reset value is the idle pin level, so key_s reads "released" out of reset.
   sync_2ff #(
      .RST_VAL (KEY_ACTIVE_LOW)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.key_in),
      .q   (key_sync)
   );

   assign key_s = key_sync ^ KEY_ACTIVE_LOW;

   key_state_t        state_q, state_d;
   logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
   logic [LONG_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              long_flag_q, long_flag_d;
   logic              key_level_q, key_level_d;
   logic              press_q, press_d;
   logic              release_q, release_d;
   logic              short_q, short_d;
   logic              long_q, long_d;
   mode_t             mode_q, mode_d;

   logic db_diff;
   logic db_done;
   logic hold_at_last;
   logic long_fire;

   always_comb begin
      db_diff      = key_s != key_level_q;
      db_done      = db_diff && (db_cnt_q == DB_LAST);
      hold_at_last = hold_cnt_q == HOLD_LAST;
      long_fire    = (state_q != IDLE) && hold_at_last && !long_flag_q;

      // Cleared on acceptance too: key_level flips, so the next compare is equal.
      db_cnt_d = (db_diff && !db_done) ? db_cnt_q + 1'b1 : '0;

      state_d     = state_q;
      key_level_d = key_level_q;
      hold_cnt_d  = hold_cnt_q;
      long_flag_d = long_flag_q;
      mode_d      = mode_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      short_d     = 1'b0;
      long_d      = 1'b0;

      // Hold time runs through release debounce so a long press can still land there.
      if ((state_q != IDLE) && !hold_at_last) begin
         hold_cnt_d = hold_cnt_q + 1'b1;
      end

      if (long_fire) begin
         long_d      = 1'b1;
         long_flag_d = 1'b1;
         mode_d      = MODE_SLOW;
      end

      unique case (state_q)
         IDLE: begin
            if (db_done) begin
               state_d     = DOWN;
               key_level_d = 1'b1;
               press_d     = 1'b1;
               hold_cnt_d  = '0;
               long_flag_d = 1'b0;
            end
         end
         DOWN: begin
            if (!key_s) begin
               state_d = REL_DB;
            end
         end
         REL_DB: begin
            if (key_s) begin
               state_d = DOWN;
            end else if (db_done) begin
               state_d     = IDLE;
               key_level_d = 1'b0;
               release_d   = 1'b1;
               // A long press landing on the release edge suppresses the short.
               if (!long_flag_q && !long_fire) begin
                  short_d = 1'b1;
                  mode_d  = mode_next(mode_q);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         db_cnt_q    <= '0;
         hold_cnt_q  <= '0;
         long_flag_q <= 1'b0;
         key_level_q <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         short_q     <= 1'b0;
         long_q      <= 1'b0;
         mode_q      <= MODE_SLOW;
      end else begin
         state_q     <= state_d;
         db_cnt_q    <= db_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
         long_flag_q <= long_flag_d;
         key_level_q <= key_level_d;
         press_q     <= press_d;
         release_q   <= release_d;
         short_q     <= short_d;
         long_q      <= long_d;
         mode_q      <= mode_d;
      end
   end

   assign bus.key_level     = key_level_q;
   assign bus.press_pulse   = press_q;
   assign bus.release_pulse = release_q;
   assign bus.short_pulse   = short_q;
   assign bus.long_pulse    = long_q;
   assign bus.mode          = mode_q;

endmodule

// File: tb/tb_key_mode_debounce.sv
// Bench for key_mode_debounce: directed scenarios with literal expectations plus
// randomized key activity checked every cycle against an event-level model.
module tb_key_mode_debounce;
   import key_pkg::*;

   localparam int unsigned DB   = 4;
   localparam int unsigned LONG = 20;
   localparam bit          AL   = 1'b1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   key_mode_debounce_if bus ();

   key_mode_debounce #(
      .DB_CYCLES      (DB),
      .LONG_CYCLES    (LONG),
      .KEY_ACTIVE_LOW (AL)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #20 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int n_press  = 0;
   int n_rel    = 0;
   int n_short  = 0;
   int n_long   = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
      end
   endtask

   // Model: key_s is the pressed sample taken two edges earlier; a level change
   // is accepted once key_s has disagreed for DB consecutive edges; a long press
   // fires exactly LONG edges after the press edge.
   bit raw_q[$];
   bit m_level;
   int m_run;
   int m_edge;
   int m_press_edge;
   bit m_long_done;
   int m_mode;
   bit e_press, e_rel, e_short, e_long;

   task automatic model_reset();
      raw_q.delete();
      m_level      = 1'b0;
      m_run        = 0;
      m_edge       = 0;
      m_press_edge = 0;
      m_long_done  = 1'b0;
      m_mode       = 0;
      e_press      = 1'b0;
      e_rel        = 1'b0;
      e_short      = 1'b0;
      e_long       = 1'b0;
   endtask

   task automatic model_step();
      bit ks;
      bit accept;
      bit differ;
      raw_q.push_back(bus.key_in == !AL);
      if (raw_q.size() > 3) void'(raw_q.pop_front());
      ks = (raw_q.size() == 3) ? raw_q[0] : 1'b0;
      m_edge++;
      e_press = 1'b0;
      e_rel   = 1'b0;
      e_short = 1'b0;
      e_long  = 1'b0;
      differ  = ks != m_level;
      accept  = differ && (m_run == int'(DB) - 1);
      if (m_level && !m_long_done && (m_edge - m_press_edge == int'(LONG))) begin
         e_long      = 1'b1;
         m_long_done = 1'b1;
         m_mode      = 0;
      end
      if (accept && !m_level) begin
         e_press      = 1'b1;
         m_level      = 1'b1;
         m_press_edge = m_edge;
         m_long_done  = 1'b0;
      end else if (accept) begin
         e_rel   = 1'b1;
         m_level = 1'b0;
         if (!m_long_done) begin
            e_short = 1'b1;
            m_mode  = (m_mode + 1) % 4;
         end
      end
      m_run = accept ? 0 : (differ ? m_run + 1 : 0);
   endtask

   // Single compare process: model advances on the active edge, DUT is compared
   // on the falling edge.
   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         if (!rst) model_step();
         @(negedge clk);
         if (rst) model_reset();
         check("key_level", int'(bus.key_level), int'(m_level));
         check("press_pulse", int'(bus.press_pulse), int'(e_press));
         check("release_pulse", int'(bus.release_pulse), int'(e_rel));
         check("short_pulse", int'(bus.short_pulse), int'(e_short));
         check("long_pulse", int'(bus.long_pulse), int'(e_long));
         check("mode", int'(bus.mode), m_mode);
         n_press = n_press + int'(bus.press_pulse);
         n_rel   = n_rel + int'(bus.release_pulse);
         n_short = n_short + int'(bus.short_pulse);
         n_long  = n_long + int'(bus.long_pulse);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #2;
      end
   endtask

   task automatic set_key(input bit pressed);
      bus.key_in = pressed ? !AL : AL;
   endtask

   // Edges until the selected strobe is seen (1 = first edge), -1 on timeout.
   task automatic wait_pulse(input int which, input int budget, output int lat);
      bit hit;
      lat = -1;
      for (int i = 1; i <= budget; i++) begin
         @(posedge clk);
         #1;
         case (which)
            0:       hit = bus.press_pulse;
            1:       hit = bus.release_pulse;
            default: hit = bus.long_pulse;
         endcase
         if (hit) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(3);
   endtask

   task automatic short_press();
      set_key(1'b1);
      tick(10);
      set_key(1'b0);
      tick(12);
   endtask

   initial begin
      int lat;
      int b_press, b_rel, b_short, b_long;
      int exp_mode;

      bus.key_in = AL;
      rst = 1'b1;
      tick(3);
      check("reset_key_level", int'(bus.key_level), 0);
      check("reset_mode", int'(bus.mode), 0);
      rst = 1'b0;
      tick(3);

      // Clean short press
      b_long = n_long;
      set_key(1'b1);
      wait_pulse(0, 30, lat);
      check("short_press_latency", lat, 6);
      tick(5);
      set_key(1'b0);
      wait_pulse(1, 30, lat);
      check("release_latency", lat, 6);
      check("short_with_release", int'(bus.short_pulse), 1);
      check("short_press_mode", int'(bus.mode), 1);
      tick(4);
      check("short_press_no_long", n_long - b_long, 0);

      // Bounce rejection
      do_reset();
      b_press = n_press;
      b_rel   = n_rel;
      repeat (5) begin
         set_key(1'b1);
         tick(3);
         set_key(1'b0);
         tick(1);
      end
      tick(12);
      check("bounce_press_count", n_press - b_press, 0);
      check("bounce_release_count", n_rel - b_rel, 0);
      check("bounce_key_level", int'(bus.key_level), 0);
      check("bounce_mode", int'(bus.mode), 0);

      // Mode wrap: 1, 2, 3, 0
      do_reset();
      b_short = n_short;
      b_rel   = n_rel;
      for (int k = 1; k <= 4; k++) begin
         short_press();
         exp_mode = k % 4;
         check("wrap_mode", int'(bus.mode), exp_mode);
      end
      check("wrap_short_count", n_short - b_short, 4);
      check("wrap_release_count", n_rel - b_rel, 4);

      // Long press from mode 2
      do_reset();
      short_press();
      short_press();
      check("long_start_mode", int'(bus.mode), 2);
      b_short = n_short;
      b_long  = n_long;
      set_key(1'b1);
      wait_pulse(0, 30, lat);
      check("long_press_latency", lat, 6);
      wait_pulse(2, 40, lat);
      check("long_after_press", lat, 20);
      check("long_mode_cleared", int'(bus.mode), 0);
      tick(14);
      set_key(1'b0);
      wait_pulse(1, 30, lat);
      check("long_release_latency", lat, 6);
      check("long_release_no_short", int'(bus.short_pulse), 0);
      tick(4);
      check("long_mode_after", int'(bus.mode), 0);
      check("long_count", n_long - b_long, 1);
      check("long_short_count", n_short - b_short, 0);

      // Release glitch keeps hold time
      do_reset();
      b_press = n_press;
      b_rel   = n_rel;
      b_short = n_short;
      b_long  = n_long;
      set_key(1'b1);
      tick(10);
      set_key(1'b0);
      tick(2);
      set_key(1'b1);
      tick(15);
      set_key(1'b0);
      tick(12);
      check("glitch_press_count", n_press - b_press, 1);
      check("glitch_release_count", n_rel - b_rel, 1);
      check("glitch_long_count", n_long - b_long, 1);
      check("glitch_short_count", n_short - b_short, 0);

      // Reset while held in DOWN with mode 3
      do_reset();
      short_press();
      short_press();
      short_press();
      set_key(1'b1);
      wait_pulse(0, 30, lat);
      tick(3);
      check("midrst_key_level", int'(bus.key_level), 1);
      check("midrst_mode_before", int'(bus.mode), 3);
      rst = 1'b1;
      #3;
      check("midrst_async_key_level", int'(bus.key_level), 0);
      check("midrst_async_mode", int'(bus.mode), 0);
      check("midrst_async_press", int'(bus.press_pulse), 0);
      check("midrst_async_long", int'(bus.long_pulse), 0);
      tick(1);
      rst = 1'b0;
      wait_pulse(0, 30, lat);
      check("midrst_repress_latency", lat, 6);
      tick(2);
      set_key(1'b0);
      tick(12);

      // Randomized activity, mostly bouncy with some long holds and resets
      do_reset();
      for (int s = 0; s < 400; s++) begin
         int len;
         if ($urandom_range(0, 59) == 0) begin
            rst = 1'b1;
            tick(1);
            rst = 1'b0;
         end
         set_key(1'($urandom_range(0, 1)));
         len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 45))
                                           : int'($urandom_range(1, 6));
         tick(len);
      end
      set_key(1'b0);
      tick(15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
